psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Downstream stage of the processing element column.
- Takes the stream of 32-bit partial sums from the bottom PE of a column and accumulates NUM_TILES consecutive values, one per input-channel tile.
- Emits one final output word per accumulation over a valid/ready handshake to the output buffer.
- Holds the running sum between tiles, so the PE array can be reused across tiles of a large reduction.

Parameters:
- INPUT_PARTIAL_SUM_BW, 32: width of the incoming partial sum; matches the PE output partial-sum width.
- ACC_BW, 32: accumulator and output data width; must be >= INPUT_PARTIAL_SUM_BW.
- TILE_CNT_BW, 8: width of the tile-count configuration and internal counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_num_tiles  input  TILE_CNT_BW  number of partial sums per result; sampled only on the first input handshake of an accumulation.
- in_valid  input  1  in_partial_sum is valid.
- in_ready  output  1  block accepts input this cycle.
- in_partial_sum  input  INPUT_PARTIAL_SUM_BW  unsigned partial sum from the PE.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  ACC_BW  accumulated result, unsigned.
- out_overflow  output  1  an addition in this accumulation exceeded 2^ACC_BW-1.
- busy  output  1  high in ACCUM or OUTPUT.

Behaviour:
- Reset values: state=IDLE, acc=0, tile_cnt=0, num_tiles_q=0, in_ready=1, out_valid=0, out_data=0, out_overflow=0, busy=0.
- Reset asserted mid-accumulation or mid-output discards all partial state; the next result restarts from scratch.
- Handshakes:
  - Input beat occurs when in_valid && in_ready.
  - Output beat occurs when out_valid && out_ready.
  - in_ready is a function of state only, with no combinational path from in_valid.
  - out_valid does not depend on out_ready.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - in_ready=1.
  - On an input beat: acc <= zero-extended in_partial_sum; tile_cnt <= 1; num_tiles_q <= cfg_num_tiles, with 0 treated as 1; ovf <= 0.
  - Goes to OUTPUT if the effective num_tiles is 1, else to ACCUM.
- ACCUM:
  - in_ready=1.
  - On an input beat: acc <= acc + in_partial_sum (see Optional Feature); tile_cnt <= tile_cnt+1; ovf |= carry out of ACC_BW.
  - When tile_cnt+1 == num_tiles_q on that beat, go to OUTPUT.
  - No beat: hold all state; idle cycles between tiles are allowed.
- OUTPUT:
  - in_ready=0, out_valid=1, out_data=acc, out_overflow=ovf.
  - On an output beat go to IDLE, with out_valid=0 next cycle.
  - out_data and out_overflow are held stable while out_ready=0.
- Latency: out_valid rises the cycle after the final input beat.
- Throughput: at best, one result per num_tiles+1 cycles; no input is accepted while in OUTPUT.
- cfg_num_tiles changes while busy are ignored until the next accumulation.
- Width rule: the addition is computed at ACC_BW+1 bits; the MSB is the carry used for the overflow flag.

Optional Feature:
- Macro: PSUM_ACC_SATURATE_EN.
- Defined: on carry, acc clamps to 2^ACC_BW-1 and stays clamped for the rest of the accumulation; out_overflow is still reported.
- Undefined: acc wraps modulo 2^ACC_BW; out_overflow is still reported.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, out_data=0, busy=0.
- cfg=3, inputs 10, 20, 30 back-to-back, out_ready=1 -> out_valid one cycle after the third beat, out_data=60, out_overflow=0; in_ready=0 for exactly that cycle.
- cfg=0, single input 7 -> treated as 1 tile; out_data=7 on the next cycle.
- cfg=2, inputs 0xFFFF_FFF0 then 0x20 -> with macro: out_data=0xFFFF_FFFF, out_overflow=1; without macro: out_data=0x10, out_overflow=1.
- cfg=2, inputs 5 then 6 with in_valid gaps of 3 cycles, out_ready low for 4 cycles -> out_data=11 held stable with out_valid=1, in_ready=0 throughout; IDLE after the out_ready beat.
- cfg=4, reset asserted after the second input -> all outputs return to reset values asynchronously; a new cfg=1, input 9 yields out_data=9.

Source files
------------

// File: rtl/psum_accumulator_if.sv
// Stream bundle between the PE column, the psum accumulator and the output buffer.
// The slave modport is the accumulator's view; the master modport drives it.
interface psum_accumulator_if #(
  parameter int INPUT_PARTIAL_SUM_BW = 32,
  parameter int ACC_BW               = 32
);
  logic                            in_valid;
  logic                            in_ready;
  logic [INPUT_PARTIAL_SUM_BW-1:0] in_partial_sum;
  logic                            out_valid;
  logic                            out_ready;
  logic [ACC_BW-1:0]               out_data;
  logic                            out_overflow;

  modport slave (
    input  in_valid,
    input  in_partial_sum,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_overflow
  );

  modport master (
    output in_valid,
    output in_partial_sum,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_overflow
  );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates NUM_TILES partial sums per result and hands the total to the output buffer.
// Define PSUM_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module psum_accumulator #(
  parameter int INPUT_PARTIAL_SUM_BW = 32,
  parameter int ACC_BW               = 32,
  parameter int TILE_CNT_BW          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TILE_CNT_BW-1:0] cfg_num_tiles,
  psum_accumulator_if.slave      bus,
  output logic                   busy
);
  localparam int SUM_BW = ACC_BW + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                 state;
  logic [ACC_BW-1:0]      acc;
  logic [TILE_CNT_BW-1:0] tile_cnt;
  logic [TILE_CNT_BW-1:0] num_tiles_q;
  logic                   ovf;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  logic [SUM_BW-1:0]      sum;
  logic                   carry;
  logic [ACC_BW-1:0]      acc_next;
  logic [TILE_CNT_BW-1:0] tile_cnt_next;
  logic [TILE_CNT_BW-1:0] num_tiles_eff;

  assign sum           = {1'b0, acc} + SUM_BW'(bus.in_partial_sum);
  assign carry         = sum[ACC_BW];
  assign tile_cnt_next = tile_cnt + TILE_CNT_BW'(1);
  assign num_tiles_eff = (cfg_num_tiles == '0) ? TILE_CNT_BW'(1) : cfg_num_tiles;

  // Once saturated, the accumulator stays pinned at full scale until the result drains.
`ifdef PSUM_ACC_SATURATE_EN
  assign acc_next = (ovf || carry) ? {ACC_BW{1'b1}} : sum[ACC_BW-1:0];
`else
  assign acc_next = sum[ACC_BW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      tile_cnt    <= '0;
      num_tiles_q <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc         <= ACC_BW'(bus.in_partial_sum);
            tile_cnt    <= TILE_CNT_BW'(1);
            num_tiles_q <= num_tiles_eff;
            ovf         <= 1'b0;
            busy_q      <= 1'b1;
            if (num_tiles_eff == TILE_CNT_BW'(1)) begin
              state       <= OUTPUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc      <= acc_next;
            tile_cnt <= tile_cnt_next;
            ovf      <= ovf | carry;
            if (tile_cnt_next == num_tiles_q) begin
              state       <= OUTPUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = acc;
  assign bus.out_overflow = ovf;
  assign busy             = busy_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Scenario-driven bench for psum_accumulator with a queue of expected results.
// Expected values follow the wrap or saturate behaviour selected by PSUM_ACC_SATURATE_EN.
module tb_psum_accumulator;
  logic       clk;
  logic       rst;
  logic [7:0] cfg_num_tiles;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  psum_accumulator_if #(.INPUT_PARTIAL_SUM_BW(32), .ACC_BW(32)) bus ();

  psum_accumulator #(
    .INPUT_PARTIAL_SUM_BW(32),
    .ACC_BW(32),
    .TILE_CNT_BW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_num_tiles(cfg_num_tiles),
    .bus(bus),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model for one accumulation, independent of the DUT internals.
  function automatic exp_t model(input logic [31:0] vals[$]);
    logic [32:0] s;
    exp_t r;
    r.data = vals[0];
    r.ovf  = 1'b0;
    for (int i = 1; i < vals.size(); i++) begin
      s = {1'b0, r.data} + {1'b0, vals[i]};
      if (s[32]) r.ovf = 1'b1;
`ifdef PSUM_ACC_SATURATE_EN
      r.data = r.ovf ? 32'hFFFF_FFFF : s[31:0];
`else
      r.data = s[31:0];
`endif
    end
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_partial_sum = '0; bus.out_ready = 1'b1; cfg_num_tiles = '0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_out_data got %h want 0", bus.out_data); end
    vectors++; if (bus.out_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_overflow got %b want 0", bus.out_overflow); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals[$] = '{32'd10, 32'd20, 32'd30};
    sb.push_back(model(vals));
    cfg_num_tiles = 8'd3; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_partial_sum = vals[i];
      tick;
      if (i < 2) begin
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_in_ready_accum got %b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_early_out_valid got %b want 0", bus.out_valid); end
      end
    end
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_latency_out_valid got %b want 1", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_in_ready_output got %b want 0", bus.in_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy got %b want 1", busy); end
    e = sb.pop_front();
    vectors++; if (bus.out_data !== e.data) begin miscompares++; $display("[TB] FAIL b2b_out_data got %0d want %0d", bus.out_data, e.data); end
    vectors++; if (bus.out_overflow !== e.ovf) begin miscompares++; $display("[TB] FAIL b2b_out_overflow got %b want %b", bus.out_overflow, e.ovf); end
    tick;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_out_valid_drop got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_in_ready_back got %b want 1", bus.in_ready); end
  endtask

  task automatic test_zero_cfg;
    logic [31:0] vals[$] = '{32'd7};
    sb.push_back(model(vals));
    cfg_num_tiles = 8'd0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_partial_sum = 32'd7;
    tick;
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_cfg_out_valid got %b want 1", bus.out_valid); end
    e = sb.pop_front();
    vectors++; if (bus.out_data !== e.data) begin miscompares++; $display("[TB] FAIL zero_cfg_out_data got %0d want %0d", bus.out_data, e.data); end
    tick;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_cfg_busy_after got %b want 0", busy); end
  endtask

  task automatic test_overflow;
    logic [31:0] vals[$];
    int n;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) vals = '{32'hFFFF_FFF0, 32'h20};
      else        vals = '{32'hFFFF_FFF0, 32'h20, 32'h5};
      sb.push_back(model(vals));
      cfg_num_tiles = 8'(vals.size()); bus.out_ready = 1'b1;
      foreach (vals[i]) begin
        bus.in_valid = 1'b1; bus.in_partial_sum = vals[i];
        tick;
      end
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin tick; n++; end
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_timeout_%0d out_valid got %b want 1", t, bus.out_valid); end
      e = sb.pop_front();
      vectors++; if (bus.out_data !== e.data) begin miscompares++; $display("[TB] FAIL ovf_out_data_%0d got %h want %h", t, bus.out_data, e.data); end
      vectors++; if (bus.out_overflow !== e.ovf) begin miscompares++; $display("[TB] FAIL ovf_flag_%0d got %b want %b", t, bus.out_overflow, e.ovf); end
      tick;
    end
  endtask

  task automatic test_stall;
    logic [31:0] vals[$] = '{32'd5, 32'd6};
    sb.push_back(model(vals));
    cfg_num_tiles = 8'd2; bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_partial_sum = 32'd5;
    tick;
    bus.in_valid = 1'b0; bus.in_partial_sum = 32'd999;
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++; if (bus.in_ready !== 1'b1 || busy !== 1'b1 || bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_gap_%0d ready/busy/valid got %b%b%b want 110", i, bus.in_ready, busy, bus.out_valid); end
    end
    bus.in_valid = 1'b1; bus.in_partial_sum = 32'd6;
    tick;
    bus.in_partial_sum = 32'd100;
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_hold_hs_%0d valid/ready got %b%b want 10", i, bus.out_valid, bus.in_ready); end
      vectors++; if (bus.out_data !== e.data || bus.out_overflow !== e.ovf) begin miscompares++; $display("[TB] FAIL stall_hold_data_%0d got %0d/%b want %0d/%b", i, bus.out_data, bus.out_overflow, e.data, e.ovf); end
      tick;
    end
    bus.out_ready = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_idle valid/busy/ready got %b%b%b want 001", bus.out_valid, busy, bus.in_ready); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] vals[$] = '{32'd9};
    cfg_num_tiles = 8'd4; bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_partial_sum = 32'(i + 1);
      tick;
    end
    bus.in_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_busy_before got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_async_ctrl ready/valid/busy got %b%b%b want 100", bus.in_ready, bus.out_valid, busy); end
    vectors++; if (bus.out_data !== 32'd0 || bus.out_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_async_data got %0d/%b want 0/0", bus.out_data, bus.out_overflow); end
    tick;
    rst = 1'b0;
    tick;
    sb.push_back(model(vals));
    cfg_num_tiles = 8'd1;
    bus.in_valid = 1'b1; bus.in_partial_sum = 32'd9;
    tick;
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_restart_valid got %b want 1", bus.out_valid); end
    e = sb.pop_front();
    vectors++; if (bus.out_data !== e.data) begin miscompares++; $display("[TB] FAIL rmid_restart_data got %0d want %0d", bus.out_data, e.data); end
    tick;
    vectors++; if (sb.size() !== 0) begin miscompares++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_zero_cfg;
    test_overflow;
    test_stall;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
